countdown_timer: RTL and testbench

Loadable down-counting timer that pairs with the free-running up-counter block. The up-counter produces a time base. This block consumes a terminal count through a valid/ready load interface, counts it down, and signals expiry. It runs one-shot or periodic, so control logic in the simulation designs can generate delays and periodic ticks.

---
 rtl/countdown_timer.sv | 100 ++++++++++
 tb/tb_countdown_timer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counting timer, one-shot or periodic
// Accepts a terminal count over a valid/ready load port, counts it down and pulses on expiry.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load_periodic,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expired,
  output logic [WIDTH-1:0] periods
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic             periodic, periodic_nxt;
  logic [WIDTH-1:0] count_nxt, periods_nxt;
  logic             busy_nxt, expired_nxt;

  assign load_ready = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      reload   <= '0;
      periodic <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      expired  <= 1'b0;
      periods  <= '0;
    end else begin
      state    <= state_nxt;
      reload   <= reload_nxt;
      periodic <= periodic_nxt;
      count    <= count_nxt;
      busy     <= busy_nxt;
      expired  <= expired_nxt;
      periods  <= periods_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    reload_nxt   = reload;
    periodic_nxt = periodic;
    count_nxt    = count;
    busy_nxt     = busy;
    expired_nxt  = 1'b0;
    periods_nxt  = periods;
    case (state)
      IDLE: begin
        if (load_valid) begin
          if (load_value != '0) begin
            state_nxt    = RUN;
            reload_nxt   = load_value;
            periodic_nxt = load_periodic;
            count_nxt    = load_value;
            busy_nxt     = 1'b1;
            periods_nxt  = '0;
          end else begin
            // A zero load expires immediately and is always one-shot.
            expired_nxt = 1'b1;
            periods_nxt = WIDTH'(1);
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
          count_nxt = '0;
          busy_nxt  = 1'b0;
        end else if (count > WIDTH'(1)) begin
          count_nxt = count - WIDTH'(1);
        end else begin
          expired_nxt = 1'b1;
          periods_nxt = periods + WIDTH'(1);
          if (periodic) begin
            count_nxt = reload;
          end else begin
            state_nxt = IDLE;
            count_nxt = '0;
            busy_nxt  = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - randomized and directed bench for countdown_timer at WIDTH 8 and 4
// Expected values come from a timeline model: each accepted load is remembered by its start edge.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_value = '0;
  logic       load_periodic = 1'b0;
  logic       abort = 1'b0;

  logic       lr8, busy8, exp8;
  logic [7:0] count8, periods8;
  logic       lr4, busy4, exp4;
  logic [3:0] count4, periods4;

  int vectors = 0;
  int miscompares = 0;

  countdown_timer #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr8),
    .load_value(load_value), .load_periodic(load_periodic), .abort(abort),
    .count(count8), .busy(busy8), .expired(exp8), .periods(periods8)
  );

  countdown_timer #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr4),
    .load_value(load_value[3:0]), .load_periodic(load_periodic), .abort(abort),
    .count(count4), .busy(busy4), .expired(exp4), .periods(periods4)
  );

  always #5 clk = ~clk;

  // Timeline model, index 0 = WIDTH 8, index 1 = WIDTH 4.
  int edge_no = 0;
  bit act[2];
  int st[2];
  int n[2];
  bit pm[2];
  int hold[2];
  int xe[2];

  function automatic int mask(int d);
    return (d == 0) ? 255 : 15;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      act[d] = 0; st[d] = 0; n[d] = 1; pm[d] = 0; hold[d] = 0; xe[d] = -1;
    end
  endtask

  task automatic model_edge();
    edge_no++;
    for (int d = 0; d < 2; d++) begin
      int v, i;
      v = int'(load_value) & mask(d);
      if (act[d]) begin
        i = edge_no - st[d];
        if (abort) begin
          act[d] = 0;
          hold[d] = ((i - 1) / n[d]) & mask(d);
        end else if (!pm[d] && i == n[d]) begin
          act[d] = 0;
          hold[d] = 1;
          xe[d] = edge_no;
        end
      end else if (load_valid) begin
        if (v != 0) begin
          act[d] = 1; st[d] = edge_no; n[d] = v; pm[d] = load_periodic;
        end else begin
          hold[d] = 1;
          xe[d] = edge_no;
        end
      end
    end
  endtask

  function automatic logic [18:0] exp_obs(int d);
    int i, cnt, per;
    logic ex;
    if (act[d]) begin
      i = edge_no - st[d];
      cnt = n[d] - (i % n[d]);
      per = (i / n[d]) & mask(d);
      ex = (i > 0) && (i % n[d] == 0);
      return {1'b0, 1'b1, ex, 8'(cnt), 8'(per)};
    end
    return {1'b1, 1'b0, (xe[d] == edge_no), 8'd0, 8'(hold[d])};
  endfunction

  function automatic logic [18:0] dut_obs(int d);
    if (d == 0) return {lr8, busy8, exp8, count8, periods8};
    return {lr4, busy4, exp4, 4'd0, count4, 4'd0, periods4};
  endfunction

  task automatic tick(input bit lv, input logic [7:0] v, input bit per, input bit ab);
    load_valid = lv;
    load_value = v;
    load_periodic = per;
    abort = ab;
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    tick(1, 8'd5, 0, 0);
    tick(1, 8'd5, 1, 0);
    vectors++;
    if ({lr8, busy8, exp8, count8, periods8} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_w8: got %h want %h", {lr8, busy8, exp8, count8, periods8}, 19'h40000);
    end
    vectors++;
    if ({lr4, busy4, exp4, count4, periods4} !== {1'b1, 1'b0, 1'b0, 4'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL reset_w4: got %h want %h", {lr4, busy4, exp4, count4, periods4}, 11'h400);
    end
    reset = 1'b0;
    tick(0, 8'd0, 0, 0);
  endtask

  task automatic test_oneshot();
    int pulses = 0;
    tick(1, 8'd5, 0, 0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick(0, 8'd0, 0, 0);
      pulses += int'(exp8);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (dut_obs(d) !== exp_obs(d)) begin
          miscompares++;
          $display("FAIL oneshot w%0d edge %0d: got %h want %h", d ? 4 : 8, edge_no, dut_obs(d), exp_obs(d));
        end
      end
    end
    vectors++;
    if (pulses !== 1 || periods8 !== 8'd1) begin
      miscompares++;
      $display("FAIL oneshot_summary: pulses %0d periods %0d want 1 1", pulses, periods8);
    end
  endtask

  task automatic test_periodic();
    int pulses = 0;
    tick(1, 8'd3, 1, 0);
    for (int c = 1; c <= 32; c++) begin
      tick(0, 8'd0, 0, (c == 32));
      pulses += int'(exp8);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (dut_obs(d) !== exp_obs(d)) begin
          miscompares++;
          $display("FAIL periodic w%0d edge %0d: got %h want %h", d ? 4 : 8, edge_no, dut_obs(d), exp_obs(d));
        end
      end
    end
    vectors++;
    if (pulses !== 10 || periods8 !== 8'd10 || busy8 !== 1'b0 || count8 !== 8'd0) begin
      miscompares++;
      $display("FAIL periodic_abort: pulses %0d periods %0d busy %b count %0d want 10 10 0 0",
               pulses, periods8, busy8, count8);
    end
    tick(0, 8'd0, 0, 0);
  endtask

  task automatic test_zero_and_hold();
    tick(1, 8'd0, 1, 0);
    vectors++;
    if (exp8 !== 1'b1 || busy8 !== 1'b0 || periods8 !== 8'd1) begin
      miscompares++;
      $display("FAIL zero_load: expired %b busy %b periods %0d want 1 0 1", exp8, busy8, periods8);
    end
    for (int j = 0; j < 12; j++) begin
      tick(1, 8'd4, 0, 0);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (dut_obs(d) !== exp_obs(d)) begin
          miscompares++;
          $display("FAIL load_hold w%0d edge %0d: got %h want %h", d ? 4 : 8, edge_no, dut_obs(d), exp_obs(d));
        end
      end
      if (j == 4 || j == 5) begin
        vectors++;
        if ({busy8, exp8, count8} !== ((j == 4) ? {1'b0, 1'b1, 8'd0} : {1'b1, 1'b0, 8'd4})) begin
          miscompares++;
          $display("FAIL back_to_back j%0d: got busy %b expired %b count %0d", j, busy8, exp8, count8);
        end
      end
    end
    tick(0, 8'd0, 0, 1);
    tick(0, 8'd0, 0, 0);
  endtask

  task automatic test_abort_on_expiry();
    tick(1, 8'd2, 0, 0);
    tick(0, 8'd0, 0, 0);
    tick(0, 8'd0, 0, 1);
    vectors++;
    if ({lr8, busy8, exp8, count8, periods8} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL abort_expiry: got %h want %h", {lr8, busy8, exp8, count8, periods8}, 19'h40000);
    end
    tick(0, 8'd0, 0, 0);
    vectors++;
    if (exp8 !== 1'b0 || exp4 !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_expiry_late: expired %b %b want 0 0", exp8, exp4);
    end
  endtask

  task automatic test_boundary();
    tick(1, 8'd15, 1, 0);
    for (int c = 1; c <= 255; c++) begin
      tick(0, 8'd0, 0, 0);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (dut_obs(d) !== exp_obs(d)) begin
          miscompares++;
          $display("FAIL wrap w%0d edge %0d: got %h want %h", d ? 4 : 8, edge_no, dut_obs(d), exp_obs(d));
        end
      end
    end
    vectors++;
    if (periods4 !== 4'd1 || periods8 !== 8'd17) begin
      miscompares++;
      $display("FAIL periods_wrap: got %0d %0d want 1 17", periods4, periods8);
    end
    tick(0, 8'd0, 0, 1);
    tick(1, 8'd1, 1, 0);
    for (int c = 0; c < 6; c++) begin
      tick(0, 8'd0, 0, 0);
      vectors++;
      if ({exp8, exp4, count8, count4} !== {1'b1, 1'b1, 8'd1, 4'd1}) begin
        miscompares++;
        $display("FAIL reload_one c%0d: expired %b %b count %0d %0d want 1 1 1 1", c, exp8, exp4, count8, count4);
      end
    end
    tick(0, 8'd0, 0, 1);
  endtask

  task automatic test_async_reset();
    tick(1, 8'd10, 0, 0);
    for (int c = 0; c < 4; c++) tick(0, 8'd0, 0, 0);
    vectors++;
    if (count8 !== 8'd6 || busy8 !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: count %0d busy %b want 6 1", count8, busy8);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({busy8, exp8, count8, periods8, busy4, exp4, count4, periods4} !== 27'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %h want 0", {busy8, exp8, count8, periods8, busy4, exp4, count4, periods4});
    end
    @(negedge clk);
    tick(0, 8'd0, 0, 0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(0, 8'd0, 0, 0);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (dut_obs(d) !== exp_obs(d)) begin
          miscompares++;
          $display("FAIL post_reset w%0d edge %0d: got %h want %h", d ? 4 : 8, edge_no, dut_obs(d), exp_obs(d));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bit lv, per, ab;
      logic [7:0] v;
      lv = ($urandom_range(99) < 35);
      per = $urandom_range(1);
      ab = ($urandom_range(99) < 4);
      case ($urandom_range(9))
        0: v = 8'd0;
        1: v = 8'd255;
        2: v = 8'($urandom_range(255));
        default: v = 8'($urandom_range(6));
      endcase
      tick(lv, v, per, ab);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (dut_obs(d) !== exp_obs(d)) begin
          miscompares++;
          $display("FAIL random w%0d edge %0d: got %h want %h", d ? 4 : 8, edge_no, dut_obs(d), exp_obs(d));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_periodic();
    test_zero_and_hold();
    test_abort_on_expiry();
    test_boundary();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
